// File: rtl/yadmc_dpram_be.sv
// True dual-port RAM with per-lane write enables, same-address write collision
// resolution (port 0 wins), selectable read-during-write and optional output register.
module yadmc_dpram_be #(
  parameter int address_depth = 10,
  parameter int data_width    = 32,
  parameter int byte_width    = 8,
  parameter int out_reg       = 0,
  parameter int rdw_mode      = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en0,
  input  logic [address_depth-1:0]         adr0,
  input  logic [data_width/byte_width-1:0] we0,
  input  logic [data_width-1:0]            di0,
  output logic [data_width-1:0]            do0,
  output logic                             rvalid0,
  input  logic                             en1,
  input  logic [address_depth-1:0]         adr1,
  input  logic [data_width/byte_width-1:0] we1,
  input  logic [data_width-1:0]            di1,
  output logic [data_width-1:0]            do1,
  output logic                             rvalid1,
  output logic                             collision
);
  localparam int lanes = data_width / byte_width;
  localparam int words = 2 ** address_depth;

  typedef logic [data_width-1:0] word_t;
  typedef logic [lanes-1:0]      mask_t;

  word_t mem [words];
  word_t rd0_q, rd1_q;

  // Port 1 lanes are written first so port 0 overrides them on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < lanes; l++) begin
        if (en1 && we1[l]) mem[adr1][l*byte_width +: byte_width] <= di1[l*byte_width +: byte_width];
        if (en0 && we0[l]) mem[adr0][l*byte_width +: byte_width] <= di0[l*byte_width +: byte_width];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_q <= '0;
      rd1_q <= '0;
    end else begin
      if (en0) rd0_q <= mem[adr0];
      if (en1) rd1_q <= mem[adr1];
    end
  end

  mask_t byp0_mask_d, byp0_mask_q, byp1_mask_d, byp1_mask_q;
  word_t byp0_data_d, byp0_data_q, byp1_data_d, byp1_data_q;
  mask_t p1_to_0, p0_to_1;
  logic  rv0_s1_d, rv0_s1_q, rv1_s1_d, rv1_s1_q;
  logic  rv0_s2_d, rv0_s2_q, rv1_s2_d, rv1_s2_q;
  word_t do0_s2_d, do0_s2_q, do1_s2_d, do1_s2_q;
  word_t s1_do0, s1_do1;
  logic  coll_d, coll_q;

  // WRITE_FIRST: remember which lanes of the read word are overwritten this
  // cycle and with what, then patch the synchronous read result.
  always_comb begin
    p1_to_0     = (en1 && adr1 == adr0) ? we1 : '0;
    p0_to_1     = (en0 && adr0 == adr1) ? we0 : '0;
    byp0_mask_d = byp0_mask_q;
    byp0_data_d = byp0_data_q;
    byp1_mask_d = byp1_mask_q;
    byp1_data_d = byp1_data_q;
    if (en0) begin
      byp0_mask_d = (rdw_mode != 0) ? (we0 | p1_to_0) : '0;
      for (int l = 0; l < lanes; l++)
        byp0_data_d[l*byte_width +: byte_width] = we0[l] ? di0[l*byte_width +: byte_width]
                                                         : di1[l*byte_width +: byte_width];
    end
    if (en1) begin
      byp1_mask_d = (rdw_mode != 0) ? (we1 | p0_to_1) : '0;
      for (int l = 0; l < lanes; l++)
        byp1_data_d[l*byte_width +: byte_width] = p0_to_1[l] ? di0[l*byte_width +: byte_width]
                                                             : di1[l*byte_width +: byte_width];
    end
  end

  always_comb begin
    s1_do0 = rd0_q;
    s1_do1 = rd1_q;
    for (int l = 0; l < lanes; l++) begin
      if (byp0_mask_q[l]) s1_do0[l*byte_width +: byte_width] = byp0_data_q[l*byte_width +: byte_width];
      if (byp1_mask_q[l]) s1_do1[l*byte_width +: byte_width] = byp1_data_q[l*byte_width +: byte_width];
    end
    rv0_s1_d = en0;
    rv1_s1_d = en1;
    rv0_s2_d = rv0_s1_q;
    rv1_s2_d = rv1_s1_q;
    do0_s2_d = rv0_s1_q ? s1_do0 : do0_s2_q;
    do1_s2_d = rv1_s1_q ? s1_do1 : do1_s2_q;
    coll_d   = en0 && en1 && (adr0 == adr1) && |(we0 & we1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp0_mask_q <= '0;
      byp1_mask_q <= '0;
      byp0_data_q <= '0;
      byp1_data_q <= '0;
      rv0_s1_q    <= 1'b0;
      rv1_s1_q    <= 1'b0;
      rv0_s2_q    <= 1'b0;
      rv1_s2_q    <= 1'b0;
      do0_s2_q    <= '0;
      do1_s2_q    <= '0;
      coll_q      <= 1'b0;
    end else begin
      byp0_mask_q <= byp0_mask_d;
      byp1_mask_q <= byp1_mask_d;
      byp0_data_q <= byp0_data_d;
      byp1_data_q <= byp1_data_d;
      rv0_s1_q    <= rv0_s1_d;
      rv1_s1_q    <= rv1_s1_d;
      rv0_s2_q    <= rv0_s2_d;
      rv1_s2_q    <= rv1_s2_d;
      do0_s2_q    <= do0_s2_d;
      do1_s2_q    <= do1_s2_d;
      coll_q      <= coll_d;
    end
  end

  assign do0       = (out_reg != 0) ? do0_s2_q : s1_do0;
  assign do1       = (out_reg != 0) ? do1_s2_q : s1_do1;
  assign rvalid0   = (out_reg != 0) ? rv0_s2_q : rv0_s1_q;
  assign rvalid1   = (out_reg != 0) ? rv1_s2_q : rv1_s1_q;
  assign collision = coll_q;
endmodule

// File: tb/tb_yadmc_dpram_be.sv
// Drives two RAM instances (latency 1 / READ_FIRST and latency 2 / WRITE_FIRST)
// with identical stimulus and scoreboards their outputs against a reference memory.
module tb_yadmc_dpram_be;
  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1;
  logic [9:0]  adr0, adr1;
  logic [3:0]  we0, we1;
  logic [31:0] di0, di1;
  logic [31:0] do0_a, do1_a, do0_b, do1_b;
  logic        rv0_a, rv1_a, rv0_b, rv1_b, coll_a, coll_b;

  logic [31:0] mdl [1024];
  exp_t        exp_q [4][$];
  int          coll_due_q [2][$];
  logic [31:0] last [4];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  yadmc_dpram_be #(.out_reg(0), .rdw_mode(0)) dut_a (
    .clk(clk), .rst(rst),
    .en0(en0), .adr0(adr0), .we0(we0), .di0(di0), .do0(do0_a), .rvalid0(rv0_a),
    .en1(en1), .adr1(adr1), .we1(we1), .di1(di1), .do1(do1_a), .rvalid1(rv1_a),
    .collision(coll_a)
  );

  yadmc_dpram_be #(.out_reg(1), .rdw_mode(1)) dut_b (
    .clk(clk), .rst(rst),
    .en0(en0), .adr0(adr0), .we0(we0), .di0(di0), .do0(do0_b), .rvalid0(rv0_b),
    .en1(en1), .adr1(adr1), .we1(we1), .di1(di1), .do1(do1_b), .rvalid1(rv1_b),
    .collision(coll_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // Word at address a after this cycle's writes; port 0 lanes override port 1.
  function automatic logic [31:0] post_word(input logic [9:0] a);
    logic [31:0] w;
    w = mdl[a];
    for (int l = 0; l < 4; l++) begin
      if (en1 && we1[l] && adr1 == a) w[l*8 +: 8] = di1[l*8 +: 8];
      if (en0 && we0[l] && adr0 == a) w[l*8 +: 8] = di0[l*8 +: 8];
    end
    return w;
  endfunction

  task automatic check_outputs();
    logic [31:0] act_d [4];
    logic        act_v [4];
    logic        act_c [2];
    logic        due;
    exp_t        e;
    act_d = '{do0_a, do1_a, do0_b, do1_b};
    act_v = '{rv0_a, rv1_a, rv0_b, rv1_b};
    act_c = '{coll_a, coll_b};
    for (int d = 0; d < 4; d++) begin
      due = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
      chk($sformatf("rvalid[%0d]", d), {31'd0, act_v[d]}, {31'd0, due});
      if (due) begin
        e = exp_q[d].pop_front();
        chk($sformatf("rdata[%0d]", d), act_d[d], e.d);
        last[d] = e.d;
      end else begin
        chk($sformatf("hold[%0d]", d), act_d[d], last[d]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      due = (coll_due_q[k].size() > 0) && (coll_due_q[k][0] == cyc);
      chk($sformatf("collision[%0d]", k), {31'd0, act_c[k]}, {31'd0, due});
      if (due) void'(coll_due_q[k].pop_front());
    end
  endtask

  task automatic step();
    logic [31:0] new0, new1;
    exp_t        e;
    if (rst) begin
      for (int d = 0; d < 4; d++) begin
        exp_q[d].delete();
        last[d] = 32'd0;
      end
      coll_due_q[0].delete();
      coll_due_q[1].delete();
    end else begin
      new0 = post_word(adr0);
      new1 = post_word(adr1);
      if (en0) begin
        e.d = mdl[adr0]; e.due = cyc + 1; exp_q[0].push_back(e);
        e.d = new0;      e.due = cyc + 2; exp_q[2].push_back(e);
      end
      if (en1) begin
        e.d = mdl[adr1]; e.due = cyc + 1; exp_q[1].push_back(e);
        e.d = new1;      e.due = cyc + 2; exp_q[3].push_back(e);
      end
      if (en0 && en1 && adr0 == adr1 && (we0 & we1) != 4'd0) begin
        coll_due_q[0].push_back(cyc + 1);
        coll_due_q[1].push_back(cyc + 1);
      end
      mdl[adr0] = new0;
      mdl[adr1] = new1;
    end
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic acc(input logic e0, input logic [9:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                     input logic e1, input logic [9:0] a1, input logic [3:0] w1, input logic [31:0] d1);
    en0 = e0; adr0 = a0; we0 = w0; di0 = d0;
    en1 = e1; adr1 = a1; we1 = w1; di1 = d1;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) acc(1'b0, 10'd0, 4'd0, 32'd0, 1'b0, 10'd0, 4'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mdl[i] = 32'd0;
    for (int d = 0; d < 4; d++) last[d] = 32'd0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      acc(1'b1, 10'(2*i), 4'hF, 32'hA000_0000 + 32'(i), 1'b1, 10'(2*i+1), 4'hF, 32'hB000_0000 + 32'(i));
    acc(1'b1, 10'd5, 4'hF, 32'h5555_AAAA, 1'b0, 10'd0, 4'd0, 32'd0);

    // writes presented under reset are dropped
    rst = 1'b1;
    acc(1'b1, 10'd5, 4'hF, 32'hFFFF_FFFF, 1'b0, 10'd0, 4'd0, 32'd0);
    acc(1'b1, 10'd5, 4'hF, 32'hFFFF_FFFF, 1'b0, 10'd0, 4'd0, 32'd0);
    rst = 1'b0;
    acc(1'b1, 10'd5, 4'h0, 32'd0, 1'b0, 10'd0, 4'd0, 32'd0);
    idle(2);

    acc(1'b1, 10'd1, 4'hF, 32'hDEAD_BEEF, 1'b0, 10'd0, 4'd0, 32'd0);
    acc(1'b0, 10'd0, 4'h0, 32'd0, 1'b1, 10'd1, 4'h0, 32'd0);
    idle(2);

    acc(1'b1, 10'd2, 4'hF, 32'h1122_3344, 1'b0, 10'd0, 4'd0, 32'd0);
    acc(1'b0, 10'd0, 4'h0, 32'd0, 1'b1, 10'd2, 4'b0101, 32'hAABB_CCDD);
    acc(1'b1, 10'd2, 4'h0, 32'd0, 1'b1, 10'd2, 4'h0, 32'd0);
    idle(2);

    acc(1'b1, 10'd3, 4'b0011, 32'h0000_00FF, 1'b1, 10'd3, 4'b0110, 32'h0000_EE00);
    acc(1'b1, 10'd3, 4'h0, 32'd0, 1'b1, 10'd3, 4'h0, 32'd0);
    acc(1'b1, 10'd3, 4'b0011, 32'h1234_5678, 1'b1, 10'd3, 4'b1100, 32'h9ABC_DEF0);
    acc(1'b1, 10'd3, 4'b0001, 32'h0000_0042, 1'b1, 10'd3, 4'h0, 32'd0);
    acc(1'b1, 10'd3, 4'h0, 32'd0, 1'b1, 10'd3, 4'h0, 32'd0);
    idle(2);

    acc(1'b1, 10'd4, 4'hF, 32'h0000_0001, 1'b0, 10'd0, 4'd0, 32'd0);
    acc(1'b1, 10'd4, 4'hF, 32'h0000_0002, 1'b1, 10'd4, 4'h0, 32'd0);
    idle(3);

    for (int i = 0; i < 16; i++) begin
      rst = (i == 7);
      acc(1'b1, 10'(i), 4'h0, 32'd0, 1'b1, 10'(15 - i), 4'h0, 32'd0);
    end
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      acc(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom);
    end
    rst = 1'b0;
    idle(4);

    for (int d = 0; d < 4; d++) chk($sformatf("drain[%0d]", d), 32'(exp_q[d].size()), 32'd0);
    for (int k = 0; k < 2; k++) chk($sformatf("drain_coll[%0d]", k), 32'(coll_due_q[k].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
